// File: rtl/raster_unproject_pkg.sv
// Shared raster/NDC types, f16 field constants and the product record passed from multiply to normalise.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package raster_unproject_pkg;

    typedef logic        [15:0] f16;
    typedef logic signed [15:0] i16;

    typedef struct packed {
        f16 y;
        f16 x;
    } vec2_f16;

    typedef struct packed {
        i16 z;
        i16 y;
        i16 x;
    } vec3_i16;

    localparam int F16_EXP_BIAS = 15;
    localparam int F16_MANT_W   = 10;
    localparam f16 F16_POS_ZERO = 16'h0000;

    // Raw significand product plus unnormalised exponent, one per NDC axis
    typedef struct packed {
        logic               sign;
        logic               zero;
        logic signed [7:0]  expo;
        logic        [21:0] prod;
    } mul_t;

endpackage

// File: rtl/raster_unproject_int16_to_f16.sv
// Signed 16-bit integer to f16 conversion with round-nearest-even; zero maps to +0.
// Latency: combinational.
// Backpressure: none, pure function of the input.
module int16_to_f16
    import raster_unproject_pkg::*;
(
    input  logic [15:0] a,
    output logic [15:0] f
);

    logic        sign;
    logic [15:0] mag;
    logic [3:0]  msb;
    logic [15:0] norm;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [10:0] mant_r;
    logic [4:0]  exp_r;

    // Sign/magnitude split, leading-one search, normalise and round to 10 mantissa bits
    always_comb begin
        sign = a[15];
        // -32768 negates to 16'h8000, which reads correctly as unsigned 32768
        mag  = sign ? (~a + 16'd1) : a;
        msb  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (mag[i]) msb = 4'(i);
        end
        norm     = mag << (4'd15 - msb);
        guard    = norm[4];
        sticky   = |norm[3:0];
        round_up = guard & (sticky | norm[5]);
        mant_r   = {1'b0, norm[14:5]} + {10'd0, round_up};
        // A rounding carry leaves mant_r[9:0] at zero and moves up one binade
        exp_r    = 5'(F16_EXP_BIAS) + {1'b0, msb} + {4'd0, mant_r[10]};
        if (mag == 16'd0) begin
            f = F16_POS_ZERO;
        end else begin
            f = {sign, exp_r, mant_r[F16_MANT_W-1:0]};
        end
    end

endmodule

// File: rtl/raster_unproject.sv
// Maps integer raster points back to f16 NDC (x*inv_w, (H-y)*inv_h) and negated f16 depth.
// Latency: 4 cycles accept-to-out_valid, 1 beat/cycle, in order.
// Backpressure: global stall; every stage holds while out_valid & !out_ready, in_ready = advance.
module raster_unproject
    import raster_unproject_pkg::*;
#(
    parameter int Z_FRAC_BITS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] rast_pt,
    input  logic [15:0] image_height,
    input  logic [31:0] inv_image_dimensions,
    output logic [31:0] ndc_pt,
    output logic [15:0] z_dist,
    output logic        out_valid,
    input  logic        out_ready
);

    // Significand product, exponent sum and sign; zero or subnormal operands flush the result
    function automatic mul_t f16_mul_raw(input f16 a, input f16 b);
        mul_t m;
        m.sign = a[15] ^ b[15];
        m.zero = (a[14:10] == 5'd0) || (b[14:10] == 5'd0);
        m.expo = $signed({3'b000, a[14:10]}) + $signed({3'b000, b[14:10]})
               - $signed(8'(F16_EXP_BIAS));
        m.prod = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
        return m;
    endfunction

    // Normalise the 22-bit product, round-nearest-even, then flush underflow or saturate to inf
    function automatic f16 f16_norm_pack(input mul_t m);
        logic [9:0]        mant;
        logic              guard;
        logic              sticky;
        logic              rnd;
        logic [10:0]       mant_r;
        logic signed [7:0] e;
        if (m.prod[21]) begin
            mant   = m.prod[20:11];
            guard  = m.prod[10];
            sticky = |m.prod[9:0];
            e      = m.expo + 8'sd1;
        end else begin
            mant   = m.prod[19:10];
            guard  = m.prod[9];
            sticky = |m.prod[8:0];
            e      = m.expo;
        end
        rnd    = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + {10'd0, rnd};
        if (mant_r[10]) e = e + 8'sd1;
        if (m.zero || e <= 8'sd0) begin
            return F16_POS_ZERO;
        end else if (e >= 8'sd31) begin
            return {m.sign, 5'h1F, 10'd0};
        end else begin
            return {m.sign, e[4:0], mant_r[9:0]};
        end
    endfunction

    vec3_i16 pt;
    vec2_f16 inv;
    logic    adv;

    logic              s1_vld;
    i16                s1_x;
    i16                s1_z;
    i16                s1_dy;
    vec2_f16           s1_inv;

    logic              s2_vld;
    f16                s2_fx;
    f16                s2_fy;
    f16                s2_fz;
    vec2_f16           s2_inv;

    logic              s3_vld;
    mul_t              s3_mx;
    mul_t              s3_my;
    f16                s3_fz;

    logic signed [16:0] dy_wide;
    i16                 dy_sat;
    f16                 cx_f;
    f16                 cy_f;
    f16                 cz_f;
    f16                 fz_adj;

    assign pt       = rast_pt;
    assign inv      = inv_image_dimensions;
    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    // H - y in 17 bits so off-screen rows cannot wrap, then clamp to the i16 range
    always_comb begin
        dy_wide = $signed({image_height[15], image_height}) - $signed({pt.y[15], pt.y});
        if (dy_wide[16] != dy_wide[15]) begin
            dy_sat = dy_wide[16] ? 16'sh8000 : 16'sh7FFF;
        end else begin
            dy_sat = dy_wide[15:0];
        end
    end

    // Stage 1: capture the point, the clamped row distance and both inverses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_x   <= '0;
            s1_z   <= '0;
            s1_dy  <= '0;
            s1_inv <= '0;
        end else if (adv) begin
            s1_vld <= in_valid;
            s1_x   <= pt.x;
            s1_z   <= pt.z;
            s1_dy  <= dy_sat;
            s1_inv <= inv;
        end
    end

    int16_to_f16 u_conv_x (.a(s1_x),  .f(cx_f));
    int16_to_f16 u_conv_y (.a(s1_dy), .f(cy_f));
    int16_to_f16 u_conv_z (.a(s1_z),  .f(cz_f));

    // Depth scaling is exact: drop the fixed-point exponent and negate, keeping zero as +0
    always_comb begin
        fz_adj = F16_POS_ZERO;
        if (cz_f[14:10] != 5'd0) begin
            fz_adj = {~cz_f[15], cz_f[14:10] - 5'(Z_FRAC_BITS), cz_f[9:0]};
        end
    end

    // Stage 2: register the converted operands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld <= 1'b0;
            s2_fx  <= '0;
            s2_fy  <= '0;
            s2_fz  <= '0;
            s2_inv <= '0;
        end else if (adv) begin
            s2_vld <= s1_vld;
            s2_fx  <= cx_f;
            s2_fy  <= cy_f;
            s2_fz  <= fz_adj;
            s2_inv <= s1_inv;
        end
    end

    // Stage 3: raw products for both axes; depth just rides along
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_vld <= 1'b0;
            s3_mx  <= '0;
            s3_my  <= '0;
            s3_fz  <= '0;
        end else if (adv) begin
            s3_vld <= s2_vld;
            s3_mx  <= f16_mul_raw(s2_fx, s2_inv.x);
            s3_my  <= f16_mul_raw(s2_fy, s2_inv.y);
            s3_fz  <= s2_fz;
        end
    end

    // Stage 4: normalise, round and pack into the output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            ndc_pt    <= '0;
            z_dist    <= '0;
        end else if (adv) begin
            out_valid <= s3_vld;
            ndc_pt    <= {f16_norm_pack(s3_my), f16_norm_pack(s3_mx)};
            z_dist    <= s3_fz;
        end
    end

endmodule

// File: tb/tb_raster_unproject.sv
module tb_raster_unproject;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] rast_pt;
    logic [15:0] image_height;
    logic [31:0] inv_image_dimensions;
    logic [31:0] ndc_pt;
    logic [15:0] z_dist;
    logic        out_valid;
    logic        out_ready;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] ny;
        logic [15:0] nx;
        logic [15:0] z;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    raster_unproject #(.Z_FRAC_BITS(3)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .rast_pt             (rast_pt),
        .image_height        (image_height),
        .inv_image_dimensions(inv_image_dimensions),
        .ndc_pt              (ndc_pt),
        .z_dist              (z_dist),
        .out_valid           (out_valid),
        .out_ready           (out_ready)
    );

    // ---------------- reference model: real arithmetic, single RNE rounding ----------------
    function automatic real pow2(input int e);
        real r;
        r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real f16_val(input logic [15:0] h);
        real m;
        if (h[14:10] == 5'd0) return 0.0;
        m = (1024.0 + real'(h[9:0])) / 1024.0 * pow2(int'(h[14:10]) - 15);
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] f16_of(input real v);
        real  m, frac, rem;
        int   e, fl;
        logic s;
        if (v == 0.0) return 16'h0000;
        s = (v < 0.0);
        m = s ? -v : v;
        e = 0;
        while (m >= pow2(e + 1)) e++;
        while (m < pow2(e)) e--;
        frac = m / pow2(e) * 1024.0;
        fl   = $rtoi(frac);
        rem  = frac - real'(fl);
        if (rem > 0.5 || (rem == 0.5 && (fl % 2) == 1)) fl++;
        if (fl == 2048) begin
            fl = 1024;
            e++;
        end
        if (e + 15 >= 31) return {s, 5'h1F, 10'h000};
        if (e + 15 <= 0)  return 16'h0000;
        return {s, 5'(e + 15), 10'(fl - 1024)};
    endfunction

    function automatic exp_t model(input logic [47:0] p, input logic [15:0] h, input logic [31:0] iv);
        exp_t r;
        int   x, y, z, dy;
        x  = int'($signed(p[15:0]));
        y  = int'($signed(p[31:16]));
        z  = int'($signed(p[47:32]));
        dy = int'($signed(h)) - y;
        if (dy > 32767)  dy = 32767;
        if (dy < -32768) dy = -32768;
        r.nx = f16_of(f16_val(f16_of(real'(x)))  * f16_val(iv[15:0]));
        r.ny = f16_of(f16_val(f16_of(real'(dy))) * f16_val(iv[31:16]));
        r.z  = f16_of(-(real'(z) / 8.0));
        return r;
    endfunction

    function automatic logic [47:0] pack_pt(input int x, input int y, input int z);
        return {16'(z), 16'(y), 16'(x)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // ---------------- scoreboard: push on accept, compare head whenever out_valid ----------------
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out: ndc=%h z=%h with no beat pending", ndc_pt, z_dist);
                end else begin
                    if ({ndc_pt, z_dist} !== {q[0].ny, q[0].nx, q[0].z}) begin
                        bad++;
                        $display("FAIL scoreboard: actual ndc=%h z=%h required ndc=%h z=%h",
                                 ndc_pt, z_dist, {q[0].ny, q[0].nx}, q[0].z);
                    end
                    if (out_ready) q.delete(0);
                end
            end
            if (in_valid && in_ready) q.push_back(model(rast_pt, image_height, inv_image_dimensions));
        end
    end

    // ---------------- stimulus helpers (called at posedge+1 with an idle pipeline) ----------------
    task automatic single(input string tag, input int x, input int y, input int z,
                          input logic [15:0] enx, input logic [15:0] eny, input logic [15:0] ez);
        int lat;
        in_valid = 1'b1;
        rast_pt  = pack_pt(x, y, z);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 4);
        chk({tag, "_ndc_x"}, ndc_pt[15:0], enx);
        chk({tag, "_ndc_y"}, ndc_pt[31:16], eny);
        chk({tag, "_z"}, z_dist, ez);
        @(posedge clk); #1;
    endtask

    logic [47:0] vec [8];

    task automatic burst(input string tag, input int stall_start);
        int sent  = 0;
        int nhs   = 0;
        int first = -1;
        int last  = -1;
        logic acc;
        fork
            begin
                while (sent < 8) begin
                    in_valid = 1'b1;
                    rast_pt  = vec[sent];
                    @(negedge clk);
                    acc = in_ready;
                    @(posedge clk); #1;
                    if (acc) sent++;
                end
                in_valid = 1'b0;
            end
            begin
                for (int c = 1; c <= 24; c++) begin
                    @(posedge clk); #1;
                    if (c == stall_start)     out_ready = 1'b0;
                    if (c == stall_start + 3) out_ready = 1'b1;
                    @(negedge clk);
                    if (!out_ready) begin
                        chk({tag, "_stall_in_ready"}, in_ready, 0);
                        chk({tag, "_stall_out_valid"}, out_valid, 1);
                    end
                    if (out_valid && out_ready) begin
                        nhs++;
                        if (first < 0) first = c;
                        last = c;
                    end
                end
            end
        join
        chk({tag, "_first_out_cycle"}, first, 4);
        chk({tag, "_beats_out"}, nhs, 8);
        chk({tag, "_span"}, last - first + 1, (stall_start > 0) ? 11 : 8);
        chk({tag, "_drained"}, q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int nv;
        rst                  = 1'b0;
        in_valid             = 1'b0;
        out_ready            = 1'b1;
        rast_pt              = '0;
        image_height         = 16'd480;
        inv_image_dimensions = {16'h1844, 16'h1666};
        vec[0] = pack_pt(1, 1, 1);
        vec[1] = pack_pt(-1, 479, -8);
        vec[2] = pack_pt(639, 240, 100);
        vec[3] = pack_pt(-640, 481, -1);
        vec[4] = pack_pt(32767, -32768, 32767);
        vec[5] = pack_pt(-32768, 32767, -32768);
        vec[6] = pack_pt(100, 1000, 7);
        vec[7] = pack_pt(5, -5, 12345);

        #1 rst = 1'b1;
        #2;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_ndc", ndc_pt, 0);
        chk("reset_z", z_dist, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_in_ready", in_ready, 1);

        single("centre", 320, 0, 16, 16'h3800, 16'h3C00, 16'hC000);
        single("zero", 0, 480, 0, 16'h0000, 16'h0000, 16'h0000);
        single("neg_x", -320, 0, 16, 16'hB800, 16'h3C00, 16'hC000);

        burst("burst", -100);
        burst("stall", 6);

        inv_image_dimensions = {16'h1844, 16'h7BFF};
        single("pos_inf", 32767, 0, 16, 16'h7C00, 16'h3C00, 16'hC000);
        single("neg_inf", -32768, 0, 16, 16'hFC00, 16'h3C00, 16'hC000);
        inv_image_dimensions = {16'h1844, 16'h0200};
        single("subnorm_inv", 320, 0, -8, 16'h0000, 16'h3C00, 16'h3C00);
        inv_image_dimensions = {16'h1844, 16'h1666};

        // four beats accepted: the first is at the output, three still in flight
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            rast_pt  = vec[k];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("pre_rst_out_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ndc", ndc_pt, 0);
        chk("rst_z", z_dist, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        nv = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid) nv++;
        end
        chk("post_rst_silent", nv, 0);
        single("post_rst", 320, 0, 16, 16'h3800, 16'h3C00, 16'hC000);
        chk("final_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
